// File: rtl/mod_n_loadable_down_counter_pkg.sv
// rtl/mod_n_loadable_down_counter_pkg.sv - shared state encodings and load-range helper for the mod-N down counter
package mod_n_loadable_down_counter_pkg;

    // Encodings shared with the up-counter family
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A load value is usable only if it lies in 1..modulus-1
    function automatic logic load_in_range(input int unsigned value, input int unsigned modulus);
        return (value >= 1) && (value < modulus);
    endfunction

endpackage

// File: rtl/mod_n_loadable_down_counter_if.sv
// rtl/mod_n_loadable_down_counter_if.sv - control/status bundle for the mod-N down counter
interface mod_n_loadable_down_counter_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             one_shot;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             load_err;

    modport master (
        output enable, load, din, one_shot,
        input  count, tc, busy, load_err
    );

    modport slave (
        input  enable, load, din, one_shot,
        output count, tc, busy, load_err
    );
endinterface

// File: rtl/mod_n_loadable_down_counter_tick_prescaler.sv
// rtl/mod_n_loadable_down_counter_tick_prescaler.sv - divides run cycles into one tick per (prescale+1)
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] cnt;

    assign tick = run && (cnt == prescale);

    // Count run cycles; restart after each tick, freeze while not running
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (run) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + PRESCALE_W'(1);
            end
        end
    end
endmodule

// File: rtl/mod_n_loadable_down_counter.sv
// rtl/mod_n_loadable_down_counter.sv - mod-N loadable down counter/timer; optional prescaler via MOD_DOWN_PRESCALE_EN
module mod_n_loadable_down_counter #(
    parameter int WIDTH      = 4,
    parameter int MODULUS    = 12,
    parameter int PRESCALE_W = 4
) (
    input logic                         clock,
    input logic                         reset,
`ifdef MOD_DOWN_PRESCALE_EN
    input logic [PRESCALE_W-1:0]        prescale,
`endif
    mod_n_loadable_down_counter_if.slave bus
);
    import mod_n_loadable_down_counter_pkg::*;

    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || (2 ** WIDTH) < MODULUS || PRESCALE_W < 1) begin : g_param_check
        $error("mod_n_loadable_down_counter: illegal WIDTH/MODULUS/PRESCALE_W");
    end

    state_t           state, state_next;
    logic [WIDTH-1:0] count, count_next;
    logic             tc, tc_next;
    logic             busy, busy_next;
    logic             load_err, load_err_next;
    logic             load_valid;
    logic             tick;

    assign load_valid = load_in_range(32'(bus.din), MODULUS);

`ifdef MOD_DOWN_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_prescaler (
        .clock    (clock),
        .reset    (reset),
        .clr      (bus.load && load_valid),
        .run      ((state == ST_RUN) && bus.enable && !bus.load),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Register state and all outputs; reset wins over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= COUNT_MAX;
            tc       <= 1'b0;
            busy     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            tc       <= tc_next;
            busy     <= busy_next;
            load_err <= load_err_next;
        end
    end

    // Next state: load beats decrement; tc only on a decrementing 1->0 step
    always_comb begin
        state_next    = state;
        count_next    = count;
        tc_next       = 1'b0;
        load_err_next = 1'b0;

        if (bus.load) begin
            if (load_valid) begin
                count_next = bus.din;
                state_next = ST_RUN;
            end else begin
                load_err_next = 1'b1;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.enable && tick) begin
                        if (count == '0) begin
                            count_next = COUNT_MAX;
                        end else if (count == WIDTH'(1)) begin
                            count_next = '0;
                            tc_next    = 1'b1;
                            if (bus.one_shot) begin
                                state_next = ST_DONE;
                            end
                        end else begin
                            count_next = count - WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    count_next = count;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        busy_next = (state_next == ST_RUN);
    end

    assign bus.count    = count;
    assign bus.tc       = tc;
    assign bus.busy     = busy;
    assign bus.load_err = load_err;
endmodule
